// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states and flag positions.
package alu_seq_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 3;

   localparam logic [OP_W-1:0] OP_NOP_HALT = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD      = 4'b0001;
   localparam logic [OP_W-1:0] OP_SUB      = 4'b0010;
   localparam logic [OP_W-1:0] OP_MUL      = 4'b0011;
   localparam logic [OP_W-1:0] OP_DIV      = 4'b0100;
   localparam logic [OP_W-1:0] OP_MOV      = 4'b0101;
   localparam logic [OP_W-1:0] OP_SWAP     = 4'b0110;
   localparam logic [OP_W-1:0] OP_LOGIC    = 4'b0111;
   localparam logic [OP_W-1:0] OP_CMP      = 4'b1001;

   // Bit positions inside the {C, N, Z} flag word
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2,
      HALT = 2'd3
   } state_t;

   // Ops that go through the iterative unit; divide-by-zero short-circuits
   function automatic logic is_iterative(input logic [OP_W-1:0] op, input logic b_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold {product} or {remainder, quotient} once the final step has been taken.
module alu_iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned          CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);

   logic             run_q;
   logic             div_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] div_diff;
   logic             div_fits;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;

   // One iteration: mult shifts {hi,lo} right after a conditional add,
   // div shifts the next dividend bit into the remainder and trial-subtracts.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_trial = {hi_q, lo_q[WIDTH-1]};
      div_fits  = (div_trial >= {1'b0, b_q});
      div_diff  = div_trial[WIDTH-1:0] - b_q;
      if (div_q) begin
         hi_d = div_fits ? div_diff : div_trial[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], div_fits};
      end else begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         div_q <= 1'b0;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
      end else if (start) begin
         run_q <= 1'b1;
         div_q <= is_div;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
      end else if (run_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CNT_W'(1);
         if (cnt_q == LAST) run_q <= 1'b0;
      end
   end

   // High during the cycle whose closing edge performs the final iteration,
   // so the controller can leave EXEC on exactly that edge.
   assign done = run_q && (cnt_q == LAST);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execution controller: accepts one op per handshake, runs it
// (iteratively for mult/div), holds the result for write-back, latches halt.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic              in_lsel,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_lo,
   output logic [WIDTH-1:0]  out_hi,
   output logic [2:0]        out_flags,
   output logic              out_err,
   output logic              busy,
   output logic              halted
);

   state_t            state_q;
   state_t            state_d;

   logic [OP_W-1:0]   op_q;
   logic              lsel_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;

   logic              accept_c;
   logic              start_c;
   logic              md_done;
   logic [WIDTH-1:0]  md_hi;
   logic [WIDTH-1:0]  md_lo;

   logic [WIDTH:0]    sum;
   logic [WIDTH-1:0]  res_lo;
   logic [WIDTH-1:0]  res_hi;
   logic [FLAG_W-1:0] res_flags;
   logic              res_c;
   logic              res_err;
   logic              res_legal;

   assign accept_c = in_valid && in_ready;
   assign start_c  = accept_c && is_iterative(in_op, in_b == '0);

   alu_iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_c),
      .is_div (in_op == OP_DIV),
      .a      (in_a),
      .b      (in_b),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (in_op == OP_NOP_HALT)                   state_d = HALT;
               else if (is_iterative(in_op, in_b == '0))   state_d = EXEC;
               else                                        state_d = DONE;
            end
         end
         EXEC:    if (md_done) state_d = DONE;
         DONE:    if (out_valid && out_ready) state_d = IDLE;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Result datapath, evaluated from the captured operands while in DONE
   always_comb begin
      sum       = '0;
      res_lo    = '0;
      res_hi    = '0;
      res_c     = 1'b0;
      res_err   = 1'b0;
      res_legal = 1'b1;
      res_flags = '0;
      case (op_q)
         OP_ADD: begin
            sum    = {1'b0, a_q} + {1'b0, b_q};
            res_lo = sum[WIDTH-1:0];
            res_c  = sum[WIDTH];
         end
         OP_SUB: begin
            sum    = {1'b0, a_q} - {1'b0, b_q};
            res_lo = sum[WIDTH-1:0];
            res_c  = sum[WIDTH];
         end
         OP_MUL: begin
            res_hi = md_hi;
            res_lo = md_lo;
         end
         OP_DIV: begin
            if (b_q == '0) begin
               res_lo  = '1;
               res_hi  = a_q;
               res_err = 1'b1;
            end else begin
               res_hi = md_hi;
               res_lo = md_lo;
            end
         end
         OP_MOV:   res_lo = a_q;
         OP_SWAP: begin
            res_lo = b_q;
            res_hi = a_q;
         end
         OP_LOGIC: res_lo = lsel_q ? (a_q | b_q) : (a_q & b_q);
         OP_CMP:   res_lo = '0;
         default: begin
            res_legal = 1'b0;
            res_err   = 1'b1;
         end
      endcase

      if (op_q == OP_CMP) begin
         res_flags[FLAG_Z] = (a_q == b_q);
         res_flags[FLAG_N] = ($signed(a_q) < $signed(b_q));
         res_flags[FLAG_C] = (a_q < b_q);
      end else if (res_legal) begin
         res_flags[FLAG_Z] = (res_lo == '0);
         res_flags[FLAG_N] = res_lo[WIDTH-1];
         res_flags[FLAG_C] = res_c;
      end
   end

   // State register and status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_ready <= (state_d == IDLE);
         busy     <= (state_d == EXEC);
         halted   <= (state_d == HALT);
      end
   end

   // Operand capture at accept; later input changes are ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q   <= '0;
         lsel_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
      end else if (accept_c) begin
         op_q   <= in_op;
         lsel_q <= in_lsel;
         a_q    <= in_a;
         b_q    <= in_b;
      end
   end

   // Output holding registers: load once on the first DONE cycle, hold until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_lo    <= '0;
         out_hi    <= '0;
         out_flags <= '0;
         out_err   <= 1'b0;
      end else if ((state_q == DONE) && !out_valid) begin
         out_valid <= 1'b1;
         out_lo    <= res_lo;
         out_hi    <= res_hi;
         out_flags <= res_flags;
         out_err   <= res_err;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_alu_sequencer;

   localparam int unsigned W = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_op;
   logic          in_lsel;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_lo;
   logic [W-1:0]  out_hi;
   logic [2:0]    out_flags;
   logic          out_err;
   logic          busy;
   logic          halted;

   alu_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_lsel   (in_lsel),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lo    (out_lo),
      .out_hi    (out_hi),
      .out_flags (out_flags),
      .out_err   (out_err),
      .busy      (busy),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic         lsel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [2:0]   flags;
      logic         err;
      int           lat;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic lsel, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                               input logic [2:0] flags, input logic err, input int lat);
      vec_t v;
      v.op = op; v.lsel = lsel; v.a = a; v.b = b;
      v.lo = lo; v.hi = hi; v.flags = flags; v.err = err; v.lat = lat;
      return v;
   endfunction

   // Reference model: plain arithmetic on the operand values
   function automatic vec_t model(input logic [3:0] op, input logic lsel,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t r;
      longint unsigned ua, ub, wide;
      logic c;
      bit legal;
      r = mk(op, lsel, a, b, '0, '0, 3'b000, 1'b0, 1);
      ua = 64'(a); ub = 64'(b); c = 1'b0; legal = 1'b1; wide = 0;
      case (op)
         4'd1: begin wide = ua + ub; r.lo = W'(wide); c = (wide >= (64'd1 << W)); end
         4'd2: begin r.lo = W'(ua - ub); c = (ua < ub); end
         4'd3: begin wide = ua * ub; r.lo = W'(wide); r.hi = W'(wide >> W); r.lat = W + 1; end
         4'd4: begin
            if (ub == 0) begin r.lo = '1; r.hi = a; r.err = 1'b1; end
            else begin r.lo = W'(ua / ub); r.hi = W'(ua % ub); r.lat = W + 1; end
         end
         4'd5: r.lo = a;
         4'd6: begin r.lo = b; r.hi = a; end
         4'd7: r.lo = lsel ? (a | b) : (a & b);
         4'd9: r.lo = '0;
         default: begin legal = 1'b0; r.err = 1'b1; end
      endcase
      if (op == 4'd9)
         r.flags = {ua < ub, $signed(a) < $signed(b), ua == ub};
      else if (legal)
         r.flags = {c, r.lo[W-1], r.lo == '0};
      return r;
   endfunction

   // Issue one op with out_ready high, check latency, busy span, result and return to IDLE
   task automatic run_vec(input vec_t v, input string name);
      int k;
      int busy_cnt;
      @(negedge clk);
      chk($sformatf("%s in_ready", name), 64'(in_ready), 64'd1);
      in_op = v.op; in_lsel = v.lsel; in_a = v.a; in_b = v.b;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom); in_lsel = 1'($urandom);
      k = 0; busy_cnt = 0;
      while (!out_valid && k < 200) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("%s latency", name), 64'(k), 64'(v.lat));
      chk($sformatf("%s busy_cycles", name), 64'(busy_cnt), (v.lat > 1) ? 64'(W) : 64'd0);
      chk($sformatf("%s lo", name), 64'(out_lo), 64'(v.lo));
      chk($sformatf("%s hi", name), 64'(out_hi), 64'(v.hi));
      chk($sformatf("%s flags", name), 64'(out_flags), 64'(v.flags));
      chk($sformatf("%s err", name), 64'(out_err), 64'(v.err));
      @(posedge clk); #1;
      chk($sformatf("%s single_beat", name), 64'(out_valid), 64'd0);
      chk($sformatf("%s back_idle", name), 64'(in_ready), 64'd1);
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[$];
   vec_t v;

   initial begin : main
      int k;
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_lsel = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b0;

      // Reset values
      @(posedge clk); #1;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_lo_hi", {32'(out_lo), 32'(out_hi)}, 64'd0);
      chk("rst flags_err", {60'd0, out_flags, out_err}, 64'd0);
      chk("rst busy_halted", {62'd0, busy, halted}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Directed vectors with hand-derived expectations
      tbl.push_back(mk(4'd1, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b101, 0, 1));
      tbl.push_back(mk(4'd3, 0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 3'b000, 0, W + 1));
      tbl.push_back(mk(4'd4, 0, 16'd100,  16'd7,    16'd14,   16'd2,    3'b000, 0, W + 1));
      tbl.push_back(mk(4'd4, 0, 16'd5,    16'd0,    16'hFFFF, 16'd5,    3'b010, 1, 1));
      tbl.push_back(mk(4'd9, 0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 3'b010, 0, 1));
      tbl.push_back(mk(4'd6, 0, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 3'b000, 0, 1));
      tbl.push_back(mk(4'hF, 0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 3'b000, 1, 1));
      tbl.push_back(mk(4'd2, 0, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 3'b110, 0, 1));
      tbl.push_back(mk(4'd2, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b001, 0, 1));
      tbl.push_back(mk(4'd5, 0, 16'h8001, 16'h1234, 16'h8001, 16'h0000, 3'b010, 0, 1));
      tbl.push_back(mk(4'd7, 0, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 3'b000, 0, 1));
      tbl.push_back(mk(4'd7, 1, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 3'b010, 0, 1));
      tbl.push_back(mk(4'd9, 0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b001, 0, 1));
      tbl.push_back(mk(4'd9, 0, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 3'b100, 0, 1));
      tbl.push_back(mk(4'd3, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b000, 0, W + 1));
      tbl.push_back(mk(4'd4, 0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 3'b010, 0, W + 1));
      tbl.push_back(mk(4'd8, 0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 3'b000, 1, 1));
      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Back-pressure: result held stable, held request ignored, next op right after handshake
      v = mk(4'd2, 0, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 3'b110, 0, 1);
      @(negedge clk);
      in_op = v.op; in_lsel = 0; in_a = v.a; in_b = v.b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
      chk("bp latency", 64'(k), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = 4'd1; in_a = 16'h0001; in_b = 16'h0001;
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("bp hold%0d lo", i), 64'(out_lo), 64'(v.lo));
         chk($sformatf("bp hold%0d flags", i), 64'(out_flags), 64'(v.flags));
         chk($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release valid", 64'(out_valid), 64'd0);
      chk("bp release in_ready", 64'(in_ready), 64'd1);
      run_vec(mk(4'd5, 0, 16'h0042, 16'h0000, 16'h0042, 16'h0000, 3'b000, 0, 1), "bp next");

      // Reset in the middle of a multiply aborts it; request during reset is dropped
      @(negedge clk);
      in_op = 4'd3; in_a = 16'h1234; in_b = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("abort busy_before", 64'(busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; in_op = 4'd1; in_a = 16'h0001; in_b = 16'h0001;
      @(posedge clk); #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort out_valid", 64'(out_valid), 64'd0);
      chk("abort in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("abort quiet%0d", i), {62'd0, out_valid, in_ready}, 64'd1);
      end

      // Halt latches until reset
      @(negedge clk);
      in_op = 4'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_op = 4'd1; in_a = 16'h0002; in_b = 16'h0003;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("halt%0d halted", i), 64'(halted), 64'd1);
         chk($sformatf("halt%0d in_ready", i), 64'(in_ready), 64'd0);
         chk($sformatf("halt%0d no_beat", i), {62'd0, out_valid, busy}, 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("halt reset halted", 64'(halted), 64'd0);
      chk("halt reset in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); rst_n = 1'b1;

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         op = 4'($urandom_range(0, 15));
         if (op == 4'd0) op = 4'd3;
         if ($urandom_range(0, 3) == 0) op = 4'd4;
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 4) == 0) b = a;
         if (op == 4'd4 && $urandom_range(0, 3) == 0) b = '0;
         run_vec(model(op, 1'($urandom), a, b), $sformatf("rnd%0d op%0h", i, op));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execution controller that sits between instruction decode and register write-back, consuming the 4-bit ALU operation codes produced by the ALU control decoder. It accepts one operation and two operands per valid/ready handshake. Single-cycle ops complete in one cycle; multiply and divide are sequenced iteratively over WIDTH cycles. It holds the result until write-back accepts it, and latches halt.

## Interface

Parameters:
- WIDTH, 16, operand width; must be ≥ 2
- Counter width is $clog2(WIDTH+1), derived

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_op  in  4  operation code
- in_lsel  in  1  logic op select for code 0111: 0 = AND, 1 = OR
- in_a, in_b  in  WIDTH  operands (unsigned unless noted)
- out_valid  out  1  result valid
- out_ready  in  1  write-back accepts result
- out_lo, out_hi  out  WIDTH  result words
- out_flags  out  3  {C, N, Z}
- out_err  out  1  illegal op or divide-by-zero
- busy  out  1  state is EXEC
- halted  out  1  halt latched

## Operation

- Op codes:
  - 0001 add: lo = a+b, C = carry.
  - 0010 sub: lo = a−b, C = borrow.
  - 0011 mult: {hi, lo} = a×b, unsigned.
  - 0100 div: lo = a/b, hi = a%b.
  - 0101 move: lo = a.
  - 0110 swap: lo = b, hi = a.
  - 0111 logic: lo = a&b or a|b per in_lsel.
  - 1001 compare: lo = 0; Z = (a==b), N = signed a<b, C = unsigned a<b.
  - 0000 halt.
  - All others: illegal.
- hi = 0 unless stated otherwise.
- Flags for non-compare ops: Z = (lo==0), N = lo[WIDTH-1], C as above, else 0.
- States:
  - IDLE → DONE on accept of a single-cycle or illegal op.
  - IDLE → EXEC on accept of mult, or div with b ≠ 0.
  - IDLE → HALT on accept of 0000.
  - EXEC → DONE when the iteration count reaches WIDTH.
  - DONE → IDLE on out_valid && out_ready.
  - HALT is absorbing; only reset exits.
- Operands and op are captured at accept; later input changes are ignored.
- mult: shift-add, one bit per cycle, LSB first.
- div: restoring, one quotient bit per cycle, MSB first.
- Divide-by-zero: single-cycle DONE with lo = all ones, hi = a, err = 1.
- Illegal op: DONE with lo = hi = 0, flags 0, err = 1.
- Halt: no output beat; in_ready = 0 and halted = 1 until reset.
- DONE outputs are stable while out_valid && !out_ready.

## Timing

- Reset values, applied at the first rising edge with rst_n low: state IDLE, in_ready 1, out_valid 0, out_lo/out_hi/out_flags/out_err 0, busy 0, halted 0.
- Latency is measured from the accept edge N:
  - Single-cycle, illegal, and div-by-zero: out_valid high after edge N+1.
  - mult and div: busy high for exactly WIDTH cycles; out_valid high after edge N+WIDTH+1.
- No accept while out_valid is high. The next accept occurs no earlier than the edge after the output handshake.
- out_ready is ignored outside DONE.
- in_valid while in_ready is low has no effect.
- Reset mid-EXEC or mid-DONE aborts the op with no output beat and forces IDLE at that edge.
- Reset in HALT clears halted.
- in_valid and rst_n low in the same cycle: reset wins, and the request is not accepted.

## Structure

- Package alu_seq_pkg:
  - Op code localparams: OP_NOP_HALT, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOV, OP_SWAP, OP_LOGIC, OP_CMP.
  - State enum {IDLE, EXEC, DONE, HALT}.
  - Flag bit indices.
- Sub-module alu_iter_muldiv:
  - Iterative shift-add multiply / restoring divide.
  - Ports: start, is_div, a, b, done, hi, lo.
  - Instantiated once, parameterised by WIDTH.
- Top level holds the FSM, operand registers, single-cycle datapath, and output holding registers.

## Test plan

- Reset, then add a=0xFFFF b=0x0001 with out_ready=1 → one beat after N+1: lo=0x0000, flags C=1 Z=1 N=0, err=0.
- mult a=0x1234 b=0x0100 → busy 16 cycles, out_valid after edge N+17, hi=0x0012 lo=0x3400.
- div a=100 b=7 → lo=14 hi=2 after N+17. div a=5 b=0 → lo=0xFFFF hi=5 err=1 after N+1.
- compare a=0x8000 b=0x0001 → Z=0 N=1 C=0. swap a=0xAAAA b=0x5555 → lo=0x5555 hi=0xAAAA.
- Hold out_ready=0 for 5 cycles after a sub: outputs stable, in_ready=0, and a new in_valid is not accepted. Then release → single beat; the next op is accepted the following cycle.
- Assert rst_n=0 mid-mult at cycle 8 → no beat, IDLE. Op 0000 → halted=1, in_ready stays 0. Op 1111 → err=1, lo=hi=0.
